program_loader: RTL

//  Upstream boot stage of the 16-bit RISC processor. Receives a program image as a byte stream
//  (valid/ready), assembles 16-bit words and writes them into the memory unit's write port.

---
 rtl/loader_pkg.sv | 34 +++
 rtl/loader_word_assembler.sv | 38 +++
 rtl/program_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, framing constants and small decode helpers
// for the program loader.
package loader_pkg;

  localparam int BYTE_BITS      = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int WORD_BITS      = BYTE_BITS * BYTES_PER_WORD;
  localparam int HDR_BYTES      = 4;

  typedef enum logic [3:0] {
    S_ADDR_HI = 4'd0,
    S_ADDR_LO = 4'd1,
    S_CNT_HI  = 4'd2,
    S_CNT_LO  = 4'd3,
    S_DATA_HI = 4'd4,
    S_DATA_LO = 4'd5,
    S_WRITE   = 4'd6,
    S_CSUM    = 4'd7,
    S_DONE    = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  // States in which a stream byte may be accepted.
  function automatic logic is_rx_state(input state_t s);
    return (s inside {S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
                      S_DATA_HI, S_DATA_LO, S_CSUM});
  endfunction

  // States that receive the first (most significant) byte of a 16-bit field.
  function automatic logic is_hi_byte(input state_t s);
    return (s inside {S_ADDR_HI, S_CNT_HI, S_DATA_HI});
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: pairs an MSB-first byte stream into 16-bit words.
// The high byte is held in a register; the word is presented combinationally
// together with the low byte so it can be consumed in the same cycle.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic                 hi_sel,
  input  logic [BYTE_BITS-1:0] byte_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_ready
);

  logic [BYTE_BITS-1:0] hi_q, hi_d;

  // Capture the high byte when it is accepted; otherwise hold.
  always_comb begin
    hi_d = hi_q;
    if (byte_valid && hi_sel) begin
      hi_d = byte_in;
    end
  end

  // High-byte holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign word       = {hi_q, byte_in};
  assign word_ready = byte_valid & ~hi_sel;

endmodule

// File: rtl/program_loader.sv
// program_loader: boot stage that receives a framed program image as a byte
// stream, writes it word by word into program memory and releases the CPU
// reset once the whole image is in place.
// Optional trailing XOR checksum of the payload: define LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int word_size = 16,
  parameter int addr_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t               state_q, state_d;
  logic [addr_size-1:0] cur_addr_q, cur_addr_d;
  logic [WORD_BITS-1:0] remaining_q, remaining_d;
  logic [addr_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_data_q, mem_data_d;
  logic                 mem_write_q, mem_write_d;
  logic                 done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
  logic                 error_q, error_d;
`endif

  logic                 accept;
  logic                 hi_sel;
  logic [WORD_BITS-1:0] asm_word;
  logic                 asm_ready;

  // Handshake: only receive states take bytes, and never while in reset.
  always_comb begin
    rx_ready = is_rx_state(state_q) & ~rst;
    accept   = rx_valid & rx_ready;
    hi_sel   = is_hi_byte(state_q);
  end

  loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (accept),
    .hi_sel     (hi_sel),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  // Frame sequencing, address/count bookkeeping and write-port staging.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_ADDR_HI: if (accept) state_d = S_ADDR_LO;
      S_ADDR_LO: begin
        if (asm_ready) begin
          cur_addr_d = addr_size'(asm_word);
          state_d    = S_CNT_HI;
        end
      end
      S_CNT_HI: if (accept) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (asm_ready) begin
          remaining_d = asm_word;
          state_d     = (asm_word == '0) ? END_STATE : S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (asm_ready) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          // Stage the write so address/data/strobe line up in S_WRITE.
          mem_addr_d  = cur_addr_q;
          mem_data_d  = word_size'(asm_word);
          mem_write_d = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        cur_addr_d  = cur_addr_q + addr_size'(1);
        remaining_d = remaining_q - WORD_BITS'(1);
        state_d     = (remaining_q == WORD_BITS'(1)) ? END_STATE : S_DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = state_q;
    endcase
    // Completion flags are sticky and set on the edge that enters the state.
    done_d = done_q | (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    error_d = error_q | (state_d == S_ERROR);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ADDR_HI;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      done_q      <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running payload checksum and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      csum_q  <= csum_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_write = mem_write_q;
  assign done      = done_q;
  assign cpu_rst   = ~done_q;

endmodule
